// File: rtl/risc_pkg.sv
// Shared RISC core definitions: opcodes, instruction phase numbers and the
// phase sequencer state encoding.
package risc_pkg;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  localparam logic [2:0] PH_FETCH0 = 3'd0;
  localparam logic [2:0] PH_FETCH1 = 3'd1;
  localparam logic [2:0] PH_FETCH2 = 3'd2;
  localparam logic [2:0] PH_FETCH3 = 3'd3;
  localparam logic [2:0] PH_EXEC4  = 3'd4;
  localparam logic [2:0] PH_EXEC5  = 3'd5;
  localparam logic [2:0] PH_EXEC6  = 3'd6;
  localparam logic [2:0] PH_EXEC7  = 3'd7;
  localparam logic [2:0] PH_HALT   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HALTED = 3'd4
  } seq_state_t;

endpackage

// File: rtl/phase_counter.sv
// Three-bit instruction phase counter with enable, async clear and a wrap
// flag that is high when an enabled count leaves the last phase.
module phase_counter
  import risc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic [2:0] cnt_o,
  output logic       wrap_o
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  // Next count: advance by one when enabled, 7 rolls over to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = cnt_q + 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= PH_FETCH0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = en_i && (cnt_q == PH_EXEC7);

endmodule

// File: rtl/phase_sequencer.sv
// Drives the Controller's instruction phase with run/stop/step/halt control
// and a retired-instruction counter. Define PHASE_SEQ_WAIT_EN for mem_busy stalls.
module phase_sequencer
  import risc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             halt,
  input  logic             mem_busy,
  output logic [2:0]       phase,
  output logic             running,
  output logic             halted,
  output logic             waiting,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  seq_state_t       state_q, state_d, base_state_s;
  logic             pend_q, pend_d, base_pend_s;
  logic             from_step_q, from_step_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             running_q, halted_q, done_q;
  logic             busy_s, adv_s, wrap_s, halt_hit_s, step_mode_s;
  logic [2:0]       phase_s;

`ifdef PHASE_SEQ_WAIT_EN
  logic waiting_q;

  assign busy_s  = mem_busy;
  assign waiting = waiting_q;

  // Registered WAIT indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waiting_q <= 1'b0;
    end else begin
      waiting_q <= (state_d == ST_WAIT);
    end
  end
`else
  logic unused_mem_busy_s;

  assign busy_s            = 1'b0;
  assign unused_mem_busy_s = mem_busy;
  assign waiting           = 1'b0;
`endif

  assign halt_hit_s  = halt && (phase_s == PH_HALT);
  assign step_mode_s = (state_q == ST_STEP) || ((state_q == ST_WAIT) && from_step_q);

  // Phase advance enable; resuming from HALTED moves phase 4 to 5 unconditionally.
  always_comb begin
    adv_s = 1'b0;
    case (state_q)
      ST_RUN, ST_STEP: adv_s = !halt_hit_s && !busy_s;
      ST_WAIT:         adv_s = !busy_s;
      ST_HALTED:       adv_s = start || step;
      default:         adv_s = 1'b0;
    endcase
  end

  phase_counter u_phase_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (adv_s),
    .cnt_o  (phase_s),
    .wrap_o (wrap_s)
  );

  // Next state, pending stop and retired-instruction count.
  always_comb begin
    base_state_s = state_q;
    base_pend_s  = pend_q;
    from_step_d  = from_step_q;
    case (state_q)
      ST_IDLE: begin
        base_pend_s = 1'b0;
        if (start) begin
          base_state_s = ST_RUN;
        end else if (step) begin
          base_state_s = ST_STEP;
        end else begin
          base_state_s = ST_IDLE;
        end
      end
      ST_RUN, ST_STEP: begin
        if (halt_hit_s) begin
          // Halt wins over both stop and a memory stall.
          base_state_s = ST_HALTED;
          base_pend_s  = 1'b0;
        end else begin
          base_pend_s = pend_q || stop;
          if (busy_s) begin
            base_state_s = ST_WAIT;
            from_step_d  = (state_q == ST_STEP);
          end else begin
            base_state_s = state_q;
          end
        end
      end
      ST_WAIT: begin
        if (busy_s) begin
          base_state_s = ST_WAIT;
        end else begin
          base_state_s = from_step_q ? ST_STEP : ST_RUN;
        end
      end
      ST_HALTED: begin
        if (start) begin
          base_state_s = ST_RUN;
        end else if (step) begin
          base_state_s = ST_STEP;
        end else begin
          base_state_s = ST_HALTED;
        end
      end
      default: begin
        base_state_s = ST_IDLE;
        base_pend_s  = 1'b0;
      end
    endcase

    // Instruction boundary: a single step or a requested stop ends in IDLE.
    if (wrap_s && (step_mode_s || base_pend_s)) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
    end else begin
      state_d = base_state_s;
      pend_d  = base_pend_s;
    end

    count_d = wrap_s ? (count_q + CNT_W'(1)) : count_q;
  end

  // Sequencer state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      from_step_q <= 1'b0;
      count_q     <= {CNT_W{1'b0}};
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      from_step_q <= from_step_d;
      count_q     <= count_d;
      running_q   <= (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_WAIT);
      halted_q    <= (state_d == ST_HALTED);
      done_q      <= wrap_s;
    end
  end

  assign phase       = phase_s;
  assign running     = running_q;
  assign halted      = halted_q;
  assign instr_done  = done_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenarios followed by
// random control traffic, all compared against a behavioural model.
module tb_phase_sequencer;

  localparam int CNT_W = 16;
`ifdef PHASE_SEQ_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  localparam int EXP_LEN   = WAIT_EN ? 11 : 8;
  localparam int EXP_WAITS = WAIT_EN ? 3 : 0;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0, stop = 1'b0, step = 1'b0, halt = 1'b0, mem_busy = 1'b0;
  logic [2:0]       phase;
  logic             running, halted, waiting, instr_done;
  logic [CNT_W-1:0] instr_count;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  typedef enum int {M_IDLE, M_RUN, M_STEP, M_HALTED} m_mode_t;
  m_mode_t m_mode;
  bit      m_stalled, m_pending, m_done;
  int      m_phase, m_count;

  phase_sequencer #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .step        (step),
    .halt        (halt),
    .mem_busy    (mem_busy),
    .phase       (phase),
    .running     (running),
    .halted      (halted),
    .waiting     (waiting),
    .instr_done  (instr_done),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = M_IDLE; m_stalled = 1'b0; m_pending = 1'b0; m_done = 1'b0;
    m_phase = 0; m_count = 0;
  endtask

  // One clock of the control rules, applied to the inputs seen at that edge.
  task automatic model_tick(input bit st, input bit sp, input bit stp, input bit hl, input bit mb);
    bit adv;
    adv = 1'b0;
    m_done = 1'b0;
    if (m_mode == M_IDLE) begin
      if (st) m_mode = M_RUN;
      else if (stp) m_mode = M_STEP;
    end else if (m_mode == M_HALTED) begin
      if (st) begin m_mode = M_RUN; adv = 1'b1; end
      else if (stp) begin m_mode = M_STEP; adv = 1'b1; end
    end else if (m_stalled) begin
      if (!mb) begin m_stalled = 1'b0; adv = 1'b1; end
    end else if (hl && m_phase == 4) begin
      m_mode = M_HALTED; m_pending = 1'b0;
    end else begin
      if (sp) m_pending = 1'b1;
      if (WAIT_EN && mb) m_stalled = 1'b1;
      else adv = 1'b1;
    end
    if (adv) begin
      m_phase = (m_phase + 1) % 8;
      if (m_phase == 0) begin
        m_done = 1'b1;
        m_count = (m_count + 1) % (1 << CNT_W);
        if (m_mode == M_STEP || m_pending) begin
          m_mode = M_IDLE; m_pending = 1'b0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_total++;
    assert (obs === 32'(exp)) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".phase"}, phase, m_phase);
    check({tag, ".running"}, running, int'(m_mode == M_RUN || m_mode == M_STEP));
    check({tag, ".halted"}, halted, int'(m_mode == M_HALTED));
    check({tag, ".waiting"}, waiting, int'(m_stalled));
    check({tag, ".instr_done"}, instr_done, int'(m_done));
    check({tag, ".instr_count"}, instr_count, m_count);
  endtask

  task automatic cycle(input bit st, input bit sp, input bit stp, input bit hl, input bit mb);
    start = st; stop = sp; step = stp; halt = hl; mem_busy = mb;
    @(posedge clk);
    model_tick(st, sp, stp, hl, mb);
    #1;
    check_all("cyc");
  endtask

  initial begin
    int dones;
    int len;
    int waits;

    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // Start pulse, then two full instructions.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("start_phase", phase, 0);
    check("start_running", running, 1);
    dones = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("run_seq", phase, (i + 1) % 8);
      if (instr_done === 1'b1) dones++;
    end
    check("run_dones", dones, 2);
    check("run_count", instr_count, 2);

    // HLT: freeze at phase 4, then resume with start.
    for (int i = 0; i < 8 && m_phase != 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("halt_halted", halted, 1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      check("halt_hold", phase, 4);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("resume_phase", phase, 5);
    check("resume_halted", halted, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("resume_count", instr_count, 3);

    // Stop requested mid-instruction completes that instruction first.
    for (int i = 0; i < 8 && m_phase != 2; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (instr_done === 1'b1) dones++;
    end
    check("stop_dones", dones, 1);
    check("stop_phase", phase, 0);
    check("stop_running", running, 0);

    // Single step, with start asserted during it.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("step_running", running, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(i < 7, 1'b0, 1'b0, 1'b0, 1'b0);
      check("step_seq", phase, (i + 1) % 8);
    end
    check("step_idle", running, 0);
    check("step_count", instr_count, 5);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("step_stays", phase, 0);

    // Memory stall of three cycles at phase 1.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    len = 1;
    waits = 0;
    for (int j = 0; j < 20 && instr_done !== 1'b1; j++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, j < 3);
      len++;
      if (waiting === 1'b1) waits++;
    end
    check("wait_len", len, EXP_LEN);
    check("wait_cycles", waits, EXP_WAITS);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wait_stop", running, 0);

    // Random control traffic.
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(15) == 0, $urandom_range(15) == 0, $urandom_range(15) == 0,
            $urandom_range(2) == 0, $urandom_range(3) == 0);
    end

    // Asynchronous reset, then again in the middle of an instruction.
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst0");
    @(negedge clk) rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8 && m_phase != 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("arst_pre", phase, 5);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst_mid");
    @(negedge clk) rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
